control_unit: RTL and testbench

- Hardwired control sequencer for the 32-bit bus datapath.
- Sits directly upstream of the datapath and drives every register-enable, bus-out, memory and ALU control strobe it consumes.
- Consumes the IR and CON flag back from the datapath. Runs the fetch T0–T2, decode and execute microsteps one state per clock.

---
 rtl/cpu_ctrl_pkg.sv | 43 ++++
 rtl/control_unit_mem_wait_ctr.sv | 15 +
 rtl/control_unit.sv | 103 ++++++++++
 tb/tb_control_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcodes, ALU one-hot indices, sequencer states and decode helpers
package cpu_ctrl_pkg;
  localparam logic [4:0] OP_LD = 5'd0, OP_LDI = 5'd1, OP_ST = 5'd2, OP_ADD = 5'd3, OP_SUB = 5'd4,
    OP_AND = 5'd5, OP_OR = 5'd6, OP_SHR = 5'd7, OP_SHRA = 5'd8, OP_SHL = 5'd9, OP_ROR = 5'd10,
    OP_ROL = 5'd11, OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI = 5'd14, OP_MUL = 5'd15,
    OP_DIV = 5'd16, OP_NOT = 5'd18, OP_BR = 5'd19, OP_JR = 5'd20, OP_JAL = 5'd21,
    OP_IN = 5'd22, OP_OUT = 5'd23, OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_NOP = 5'd26,
    OP_HALT = 5'd27;
  localparam int ALU_ADD = 0, ALU_SUB = 1, ALU_AND = 2, ALU_OR = 3, ALU_SHR = 4, ALU_SHRA = 5,
    ALU_SHL = 6, ALU_ROR = 7, ALU_ROL = 8, ALU_MUL = 9, ALU_DIV = 10, ALU_NOT = 11;
  typedef enum logic [3:0] {RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
  function automatic logic is_alu(input logic [4:0] op);
    return op inside {OP_LDI, [OP_ADD:OP_ORI], OP_NOT};
  endfunction
  function automatic logic is_imm(input logic [4:0] op);
    return op inside {OP_LDI, OP_ADDI, OP_ANDI, OP_ORI};
  endfunction
  function automatic state_t last_step(input logic [4:0] op);
    return (op == OP_LD || op == OP_ST) ? T7 :
           (op inside {OP_BR, OP_MUL, OP_DIV}) ? T6 :
           is_alu(op) ? T5 : (op == OP_JAL) ? T4 : T3;
  endfunction
  function automatic logic [11:0] alu_sel(input logic [4:0] op);
    logic [11:0] a;
    a = '0;
    case (op)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI, OP_BR: a[ALU_ADD] = 1'b1;
      OP_SUB: a[ALU_SUB] = 1'b1;
      OP_AND, OP_ANDI: a[ALU_AND] = 1'b1;
      OP_OR, OP_ORI: a[ALU_OR] = 1'b1;
      OP_SHR: a[ALU_SHR] = 1'b1;
      OP_SHRA: a[ALU_SHRA] = 1'b1;
      OP_SHL: a[ALU_SHL] = 1'b1;
      OP_ROR: a[ALU_ROR] = 1'b1;
      OP_ROL: a[ALU_ROL] = 1'b1;
      OP_MUL: a[ALU_MUL] = 1'b1;
      OP_DIV: a[ALU_DIV] = 1'b1;
      OP_NOT: a[ALU_NOT] = 1'b1;
      default: a = '0;
    endcase
    return a;
  endfunction
endpackage

// File: rtl/control_unit_mem_wait_ctr.sv
// mem_wait_ctr: loadable down-counter; o_done is high once the count reaches zero
module mem_wait_ctr #(parameter int W = 3) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_done
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk)
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign o_done = r_cnt == '0;
endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired fetch/decode/execute sequencer driving the bus datapath strobes
module control_unit import cpu_ctrl_pkg::*; #(
  parameter int MEM_RD_CYCLES = 1,
  parameter int MEM_WR_CYCLES = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        Stop,
  output logic        Run,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic        Cout, PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout,
  output logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPortIn, CONin, r15write,
  output logic        MDRRead, RAMread, RAMwrite,
  output logic        IncPC,
  output logic        con_FF_Reset,
  output logic [11:0] ALUControl
);
  state_t r_state, w_next, w_start;
  logic [4:0] r_op, w_op;
  logic r_stop, w_wait, w_done, w_unused;
  logic [2:0] w_val;
  assign w_unused = ^IR[26:0];
  assign w_op = (r_state == T3) ? IR[31:27] : r_op;
  assign w_start = (r_stop || Stop) ? HALT : T0;
  assign w_wait = r_state == T1 || (r_state == T6 && w_op == OP_LD) || (r_state == T7 && w_op == OP_ST);
  assign w_val = (w_next == T7 && w_op == OP_ST) ? 3'(MEM_WR_CYCLES - 1) : 3'(MEM_RD_CYCLES - 1);
  assign Run = r_state != RESET && r_state != HALT;
  mem_wait_ctr #(.W(3)) u_wait (.clk(clk), .rst(clr), .i_load(w_next != r_state), .i_val(w_val), .o_done(w_done));
  always_ff @(posedge clk)
    if (clr) begin
      r_state <= RESET;
      r_op <= '0;
      r_stop <= 1'b0;
    end else begin
      r_state <= w_next;
      r_op <= w_op;
      r_stop <= r_stop | Stop;
    end
  always_comb begin
    w_next = state_t'(r_state + 4'd1);
    if (r_state == RESET) w_next = w_start;
    else if (r_state == HALT || (r_state == T3 && w_op == OP_HALT)) w_next = HALT;
    else if (w_wait && !w_done) w_next = r_state;
    else if (r_state == last_step(w_op)) w_next = w_start;
  end
  always_comb begin
    {Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, MDRout, Zhighout, Zlowout, HIout, LOout,
     InPortout, PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPortIn, CONin, r15write,
     MDRRead, RAMread, RAMwrite, IncPC, con_FF_Reset, ALUControl} = '0;
    case (r_state)
      T0: {PCout, MARin, IncPC, Zin, con_FF_Reset} = '1;
      T1: begin {Zlowout, PCin, RAMread, MDRRead} = '1; MDRin = w_done; end
      T2: {MDRout, IRin} = '1;
      T3: case (w_op)
        OP_LD, OP_ST: {Grb, BAout, Yin} = '1;
        OP_MUL, OP_DIV: {Gra, Rout, Yin} = '1;
        OP_BR: {Gra, Rout, CONin} = '1;
        OP_JR: {Gra, Rout, PCin} = '1;
        OP_JAL: {PCout, r15write} = '1;
        OP_MFHI: {HIout, Gra, Rin} = '1;
        OP_MFLO: {LOout, Gra, Rin} = '1;
        OP_IN: {InPortout, Gra, Rin} = '1;
        OP_OUT: {Gra, Rout, OutPortIn} = '1;
        default: if (is_alu(w_op)) {Grb, Rout, Yin} = '1;
      endcase
      T4: case (w_op)
        OP_LD, OP_ST: begin {Cout, Zin} = '1; ALUControl = alu_sel(w_op); end
        OP_MUL, OP_DIV: begin {Grb, Rout, Zin} = '1; ALUControl = alu_sel(w_op); end
        OP_BR: {PCout, Yin} = '1;
        OP_JAL: {Gra, Rout, PCin} = '1;
        default: if (is_alu(w_op)) begin
          Zin = 1'b1;
          ALUControl = alu_sel(w_op);
          Cout = is_imm(w_op);
          Rout = !is_imm(w_op);
          Grb = w_op == OP_NOT;
          Grc = !is_imm(w_op) && w_op != OP_NOT;
        end
      endcase
      T5: case (w_op)
        OP_LD, OP_ST: {Zlowout, MARin} = '1;
        OP_MUL, OP_DIV: {Zlowout, LOin} = '1;
        OP_BR: begin {Cout, Zin} = '1; ALUControl = alu_sel(w_op); end
        default: if (is_alu(w_op)) {Zlowout, Gra, Rin} = '1;
      endcase
      T6: case (w_op)
        OP_LD: begin {RAMread, MDRRead} = '1; MDRin = w_done; end
        OP_ST: {Gra, Rout, MDRin} = '1;
        OP_MUL, OP_DIV: {Zhighout, HIin} = '1;
        OP_BR: begin Zlowout = 1'b1; PCin = CON; end
        default: ;
      endcase
      T7: case (w_op)
        OP_LD: {MDRout, Gra, Rin} = '1;
        OP_ST: RAMwrite = 1'b1;
        default: ;
      endcase
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: per-cycle strobe checks of two control_unit instances against a step-list model
module tb_control_unit;
  typedef logic [42:0] vec_t;
  localparam vec_t NONE = '0, ONE = 43'd1;
  localparam vec_t GRA = ONE << 0, GRB = ONE << 1, GRC = ONE << 2, RIN = ONE << 3, ROUT = ONE << 4,
    BAOUT = ONE << 5, COUT = ONE << 6, PCOUT = ONE << 7, MDROUT = ONE << 8, ZHI = ONE << 9,
    ZLO = ONE << 10, HIOUT = ONE << 11, LOOUT = ONE << 12, INPOUT = ONE << 13, PCIN = ONE << 14,
    IRIN = ONE << 15, MARIN = ONE << 16, MDRIN = ONE << 17, YIN = ONE << 18, ZIN = ONE << 19,
    HIIN = ONE << 20, LOIN = ONE << 21, OUTPIN = ONE << 22, CONIN = ONE << 23, R15W = ONE << 24,
    MDRRD = ONE << 25, RAMRD = ONE << 26, RAMWR = ONE << 27, INCPC = ONE << 28, CFR = ONE << 29,
    RUN = ONE << 42;
  logic clk;
  logic [1:0] clr, CON, Stop, Run, Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, MDRout, Zhighout,
    Zlowout, HIout, LOout, InPortout, PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPortIn,
    CONin, r15write, MDRRead, RAMread, RAMwrite, IncPC, con_FF_Reset;
  logic [31:0] IR [2];
  logic [11:0] ALU [2];
  logic [1:0][42:0] obs;
  int checks = 0, errors = 0;
  vec_t exp_q[$];
  for (genvar g = 0; g < 2; g++) begin : g_dut
    control_unit #(.MEM_RD_CYCLES(g == 0 ? 1 : 3), .MEM_WR_CYCLES(g == 0 ? 1 : 2)) dut (
      .clk(clk), .clr(clr[g]), .IR(IR[g]), .CON(CON[g]), .Stop(Stop[g]), .Run(Run[g]),
      .Gra(Gra[g]), .Grb(Grb[g]), .Grc(Grc[g]), .Rin(Rin[g]), .Rout(Rout[g]), .BAout(BAout[g]),
      .Cout(Cout[g]), .PCout(PCout[g]), .MDRout(MDRout[g]), .Zhighout(Zhighout[g]),
      .Zlowout(Zlowout[g]), .HIout(HIout[g]), .LOout(LOout[g]), .InPortout(InPortout[g]),
      .PCin(PCin[g]), .IRin(IRin[g]), .MARin(MARin[g]), .MDRin(MDRin[g]), .Yin(Yin[g]),
      .Zin(Zin[g]), .HIin(HIin[g]), .LOin(LOin[g]), .OutPortIn(OutPortIn[g]), .CONin(CONin[g]),
      .r15write(r15write[g]), .MDRRead(MDRRead[g]), .RAMread(RAMread[g]), .RAMwrite(RAMwrite[g]),
      .IncPC(IncPC[g]), .con_FF_Reset(con_FF_Reset[g]), .ALUControl(ALU[g]));
    assign obs[g] = {Run[g], ALU[g], con_FF_Reset[g], IncPC[g], RAMwrite[g], RAMread[g],
      MDRRead[g], r15write[g], CONin[g], OutPortIn[g], LOin[g], HIin[g], Zin[g], Yin[g], MDRin[g],
      MARin[g], IRin[g], PCin[g], InPortout[g], LOout[g], HIout[g], Zlowout[g], Zhighout[g],
      MDRout[g], PCout[g], Cout[g], BAout[g], Rout[g], Rin[g], Grc[g], Grb[g], Gra[g]};
  end
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic vec_t alu_of(input int op);
    int b;
    case (op)
      1, 3, 12: b = 0;
      4: b = 1;
      5, 13: b = 2;
      6, 14: b = 3;
      7: b = 4;
      8: b = 5;
      9: b = 6;
      10: b = 7;
      11: b = 8;
      15: b = 9;
      16: b = 10;
      default: b = 11;
    endcase
    return ONE << (30 + b);
  endfunction
  function automatic void model(input int op, input bit con, input int rd, input int wr);
    exp_q.delete();
    exp_q.push_back(RUN | PCOUT | MARIN | INCPC | ZIN | CFR);
    for (int i = 0; i < rd; i++) exp_q.push_back(RUN | ZLO | PCIN | RAMRD | MDRRD | (i == rd - 1 ? MDRIN : NONE));
    exp_q.push_back(RUN | MDROUT | IRIN);
    case (op)
      1, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 18: begin
        exp_q.push_back(RUN | GRB | ROUT | YIN);
        exp_q.push_back(RUN | ZIN | alu_of(op) | (op inside {1, 12, 13, 14} ? COUT : ((op == 18 ? GRB : GRC) | ROUT)));
        exp_q.push_back(RUN | ZLO | GRA | RIN);
      end
      0, 2: begin
        exp_q.push_back(RUN | GRB | BAOUT | YIN);
        exp_q.push_back(RUN | COUT | alu_of(3) | ZIN);
        exp_q.push_back(RUN | ZLO | MARIN);
        if (op == 0) begin
          for (int i = 0; i < rd; i++) exp_q.push_back(RUN | RAMRD | MDRRD | (i == rd - 1 ? MDRIN : NONE));
          exp_q.push_back(RUN | MDROUT | GRA | RIN);
        end else begin
          exp_q.push_back(RUN | GRA | ROUT | MDRIN);
          for (int i = 0; i < wr; i++) exp_q.push_back(RUN | RAMWR);
        end
      end
      19: begin
        exp_q.push_back(RUN | GRA | ROUT | CONIN);
        exp_q.push_back(RUN | PCOUT | YIN);
        exp_q.push_back(RUN | COUT | alu_of(3) | ZIN);
        exp_q.push_back(RUN | ZLO | (con ? PCIN : NONE));
      end
      20: exp_q.push_back(RUN | GRA | ROUT | PCIN);
      21: begin
        exp_q.push_back(RUN | PCOUT | R15W);
        exp_q.push_back(RUN | GRA | ROUT | PCIN);
      end
      15, 16: begin
        exp_q.push_back(RUN | GRA | ROUT | YIN);
        exp_q.push_back(RUN | GRB | ROUT | alu_of(op) | ZIN);
        exp_q.push_back(RUN | ZLO | LOIN);
        exp_q.push_back(RUN | ZHI | HIIN);
      end
      22: exp_q.push_back(RUN | INPOUT | GRA | RIN);
      23: exp_q.push_back(RUN | GRA | ROUT | OUTPIN);
      24: exp_q.push_back(RUN | HIOUT | GRA | RIN);
      25: exp_q.push_back(RUN | LOOUT | GRA | RIN);
      default: exp_q.push_back(RUN);
    endcase
  endfunction
  task automatic test_reset(input int k);
    clr[k] = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) clr[k] = 1'b0;
      @(negedge clk);
      checks++;
      if (obs[k] !== NONE) begin
        errors++;
        $display("FAIL reset[%0d] cycle %0d: got %h expected %h", k, i, obs[k], NONE);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic run_instr(input int k, input logic [31:0] ir, input bit con, input int stop_at, input string name);
    IR[k] = ir;
    CON[k] = con;
    model(int'(ir[31:27]), con, k == 0 ? 1 : 3, k == 0 ? 1 : 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      Stop[k] = (i == stop_at);
      @(negedge clk);
      checks++;
      if (obs[k] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s[%0d] op %0d step %0d: got %h expected %h", name, k, ir[31:27], i, obs[k], exp_q[i]);
      end
      @(posedge clk); #1;
    end
    Stop[k] = 1'b0;
  endtask
  task automatic expect_idle(input int k, input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (obs[k] !== NONE) begin
        errors++;
        $display("FAIL %s[%0d] idle cycle %0d: got %h expected %h", name, k, i, obs[k], NONE);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_add();
    test_reset(0);
    run_instr(0, 32'h18000000, 1'b0, -1, "add");
    run_instr(0, 32'h18000000, 1'b1, -1, "add_again");
  endtask
  task automatic test_ld_st();
    test_reset(1);
    run_instr(1, 32'h00000000, 1'b0, -1, "ld_wait3");
    run_instr(1, 32'h10000000, 1'b0, -1, "st_wait2");
    run_instr(1, 32'h08000000, 1'b0, -1, "ldi");
  endtask
  task automatic test_br();
    test_reset(0);
    run_instr(0, 32'h98000000, 1'b0, -1, "br_con0");
    run_instr(0, 32'h98000000, 1'b1, -1, "br_con1");
  endtask
  task automatic test_mul_div();
    test_reset(0);
    run_instr(0, 32'h78000000, 1'b0, -1, "mul");
    run_instr(0, 32'h80000000, 1'b0, -1, "div");
  endtask
  task automatic test_halt();
    test_reset(0);
    run_instr(0, 32'hD8000000, 1'b0, -1, "halt");
    expect_idle(0, 10, "halt");
    test_reset(0);
    run_instr(0, 32'h18000000, 1'b0, -1, "after_halt");
  endtask
  task automatic test_stop();
    test_reset(1);
    run_instr(1, 32'h18000000, 1'b0, 5, "add_stop");
    expect_idle(1, 10, "stop");
    test_reset(1);
    run_instr(1, 32'h18000000, 1'b0, -1, "after_stop");
  endtask
  task automatic test_mid_reset();
    test_reset(1);
    IR[1] = 32'h00000000;
    repeat (6) begin @(posedge clk); #1; end
    test_reset(1);
    run_instr(1, 32'h18000000, 1'b0, -1, "after_mid_reset");
  endtask
  task automatic test_back_to_back(input int k, input int n);
    test_reset(k);
    for (int j = 0; j < n; j++) begin
      logic [4:0] op;
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      run_instr(k, {op, 27'($urandom)}, 1'($urandom_range(0, 1)), -1, "random");
    end
  endtask
  initial begin
    clr = 2'b11;
    CON = '0;
    Stop = '0;
    IR[0] = '0;
    IR[1] = '0;
    test_add();
    test_ld_st();
    test_br();
    test_mul_div();
    test_halt();
    test_stop();
    test_mid_reset();
    test_back_to_back(0, 40);
    test_back_to_back(1, 40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
